// File: rtl/chroma_pkg.sv
// Shared types, BT.601 integer coefficients and the output clamp for the
// YUV444 -> XRGB32 conversion stage.
package chroma_pkg;

    // Studio swing: Y spans 16..235, 8-bit fixed-point coefficients.
    localparam logic signed [19:0] K_Y_STUDIO  = 20'sd298;
    localparam logic signed [19:0] K_RV_STUDIO = 20'sd409;
    localparam logic signed [19:0] K_GU_STUDIO = 20'sd100;
    localparam logic signed [19:0] K_GV_STUDIO = 20'sd208;
    localparam logic signed [19:0] K_BU_STUDIO = 20'sd516;
    localparam logic signed [9:0]  Y_OFS_STUDIO = 10'sd16;

    // Full swing: no luma offset.
    localparam logic signed [19:0] K_Y_FULL  = 20'sd256;
    localparam logic signed [19:0] K_RV_FULL = 20'sd359;
    localparam logic signed [19:0] K_GU_FULL = 20'sd88;
    localparam logic signed [19:0] K_GV_FULL = 20'sd183;
    localparam logic signed [19:0] K_BU_FULL = 20'sd454;
    localparam logic signed [9:0]  Y_OFS_FULL = 10'sd0;

    localparam logic signed [9:0]  C_OFS = 10'sd128;
    localparam logic signed [19:0] ROUND = 20'sd128;

    localparam int unsigned PX_W     = 32;
    localparam int unsigned PX0_BASE = 0;
    localparam int unsigned PX1_BASE = 32;

    // Packed MSB-first, so v lands in bits [7:0] and pad in [31:24].
    typedef struct packed {
        logic [7:0] pad;
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_px_t;

    // Packed MSB-first, so b lands in bits [7:0] and a in [31:24].
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_px_t;

    function automatic logic [7:0] clamp_u8(input logic signed [19:0] x);
        logic signed [11:0] s;
        s = 12'(x >>> 8);
        if (s < 12'sd0)
            return 8'h00;
        else if (s > 12'sd255)
            return 8'hff;
        else
            return s[7:0];
    endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// Valid/ready stream channel carrying data, byte keep and end-of-packet marker.
interface nasti_stream_channel #(
    parameter int unsigned N_PORT     = 1,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                                  t_valid;
    logic                                  t_ready;
    logic [DATA_WIDTH-1:0]                 t_data;
    logic [N_PORT-1:0][DATA_WIDTH/8-1:0]   t_keep;
    logic                                  t_last;

    modport master (output t_valid, output t_data, output t_keep, output t_last,
                    input  t_ready);
    modport slave  (input  t_valid, input  t_data, input  t_keep, input  t_last,
                    output t_ready);
endinterface

// File: rtl/yuv_to_rgb_px.sv
// Three-stage single-pixel YUV -> RGB datapath: offsets, products, shift/clamp.
module yuv_to_rgb_px
    import chroma_pkg::*;
#(
    parameter bit         FULL_RANGE = 1'b0,
    parameter logic [7:0] ALPHA      = 8'h00
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    ce,
    input  logic    live,
    input  yuv_px_t px,
    output rgb_px_t rgb
);
    localparam logic signed [19:0] KY  = FULL_RANGE ? K_Y_FULL  : K_Y_STUDIO;
    localparam logic signed [19:0] KRV = FULL_RANGE ? K_RV_FULL : K_RV_STUDIO;
    localparam logic signed [19:0] KGU = FULL_RANGE ? K_GU_FULL : K_GU_STUDIO;
    localparam logic signed [19:0] KGV = FULL_RANGE ? K_GV_FULL : K_GV_STUDIO;
    localparam logic signed [19:0] KBU = FULL_RANGE ? K_BU_FULL : K_BU_STUDIO;
    localparam logic signed [9:0]  YO  = FULL_RANGE ? Y_OFS_FULL : Y_OFS_STUDIO;

    logic signed [9:0]  c, d, e;
    logic signed [19:0] c20, d20, e20;
    logic signed [19:0] r_acc, g_acc, b_acc;
    logic               unused_pad;

    assign c20 = 20'(c);
    assign d20 = 20'(d);
    assign e20 = 20'(e);
    assign unused_pad = ^px.pad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c     <= '0;
            d     <= '0;
            e     <= '0;
            r_acc <= '0;
            g_acc <= '0;
            b_acc <= '0;
            rgb   <= '0;
        end else if (ce) begin
            c     <= $signed({2'b00, px.y}) - YO;
            d     <= $signed({2'b00, px.u}) - C_OFS;
            e     <= $signed({2'b00, px.v}) - C_OFS;
            r_acc <= KY * c20 + KRV * e20 + ROUND;
            g_acc <= KY * c20 - KGU * d20 - KGV * e20 + ROUND;
            b_acc <= KY * c20 + KBU * d20 + ROUND;
            // Dead pixels leave every byte, alpha included, at zero.
            rgb   <= live ? {ALPHA, clamp_u8(r_acc), clamp_u8(g_acc), clamp_u8(b_acc)} : '0;
        end
    end
endmodule

// File: rtl/yuv444_to_rgb32.sv
// Two-pixel-per-beat YUV444 -> XRGB32 stream converter with a 3-stage pipeline
// and a single global advance enable driven by the output handshake.
module yuv444_to_rgb32
    import chroma_pkg::*;
#(
    parameter bit         FULL_RANGE = 1'b0,
    parameter logic [7:0] ALPHA      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    nasti_stream_channel.slave        src,
    nasti_stream_channel.master       dst
);
    logic       ce;
    logic       accept;
    logic       run;
    logic [1:0] valid_q;
    logic [1:0] last_q;
    logic [1:0] live_in, live_s1, live_s2;
    rgb_px_t    px_out [2];

    assign ce         = !dst.t_valid || dst.t_ready;
    assign src.t_ready = run && ce;
    assign accept     = src.t_valid && src.t_ready;
    assign dst.t_data = {px_out[1], px_out[0]};

    // Holds t_ready low through reset without a combinational path from rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            run <= 1'b0;
        else
            run <= 1'b1;
    end

    for (genvar n = 0; n < 2; n++) begin : g_px
        localparam int unsigned BASE = (n == 0) ? PX0_BASE : PX1_BASE;

        assign live_in[n] = (src.t_keep[0][4*n +: 4] == 4'hf);

        yuv_to_rgb_px #(
            .FULL_RANGE (FULL_RANGE),
            .ALPHA      (ALPHA)
        ) u_px (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .live (live_s2[n]),
            .px   (src.t_data[BASE +: PX_W]),
            .rgb  (px_out[n])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            last_q      <= '0;
            live_s1     <= '0;
            live_s2     <= '0;
            dst.t_valid <= 1'b0;
            dst.t_last  <= 1'b0;
            dst.t_keep  <= '0;
        end else if (ce) begin
            valid_q       <= {valid_q[0], accept};
            last_q        <= {last_q[0], accept && src.t_last};
            live_s1       <= live_in;
            live_s2       <= live_s1;
            dst.t_valid   <= valid_q[1];
            dst.t_last    <= last_q[1];
            dst.t_keep[0] <= {{4{live_s2[1]}}, {4{live_s2[0]}}};
        end
    end
endmodule

// File: tb/tb_yuv444_to_rgb32.sv
// Directed bench for yuv444_to_rgb32: colour points, latency, backpressure,
// framing, partial keep and mid-stream reset.
module tb_yuv444_to_rgb32;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned tests = 0;
    int unsigned errors = 0;
    beat_t out_q [$];
    beat_t held;
    logic  held_v = 1'b0;

    // Gray ramp results for Y = 16 + 8*i, U = V = 128.
    logic [7:0] gray [16] = '{8'h00, 8'h09, 8'h13, 8'h1C, 8'h25, 8'h2F, 8'h38, 8'h41,
                              8'h4B, 8'h54, 8'h5D, 8'h66, 8'h70, 8'h79, 8'h82, 8'h8C};

    nasti_stream_channel #(.N_PORT(1), .DATA_WIDTH(64)) src_ch ();
    nasti_stream_channel #(.N_PORT(1), .DATA_WIDTH(64)) dst_ch ();

    yuv444_to_rgb32 #(
        .FULL_RANGE (1'b0),
        .ALPHA      (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .src (src_ch),
        .dst (dst_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", 64'(dst_ch.t_valid), 64'd1);
                check("stall_data", dst_ch.t_data, held.data);
                check("stall_keep_last", {55'd0, dst_ch.t_keep, dst_ch.t_last},
                      {55'd0, held.keep, held.last});
            end
            if (dst_ch.t_valid && dst_ch.t_ready)
                out_q.push_back('{dst_ch.t_data, dst_ch.t_keep, dst_ch.t_last});
            held_v = dst_ch.t_valid && !dst_ch.t_ready;
            held   = '{dst_ch.t_data, dst_ch.t_keep, dst_ch.t_last};
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int unsigned n = 0;
        src_ch.t_valid = 1'b1;
        src_ch.t_data  = d;
        src_ch.t_keep  = k;
        src_ch.t_last  = l;
        @(negedge clk);
        while (!src_ch.t_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!src_ch.t_ready)
            check("send_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        src_ch.t_valid = 1'b0;
    endtask

    task automatic latency_beat(input string tag, input logic [63:0] d, input logic [63:0] exp);
        int unsigned lat;
        send(d, 8'hff, 1'b0);
        lat = 1;
        while (!dst_ch.t_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_data"}, dst_ch.t_data, exp);
    endtask

    task automatic wait_outputs(input string tag, input int unsigned n);
        int unsigned c = 0;
        while (out_q.size() < n && c < 500) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(out_q.size()), 64'(n));
    endtask

    initial begin
        src_ch.t_valid = 1'b0;
        src_ch.t_data  = '0;
        src_ch.t_keep  = '0;
        src_ch.t_last  = 1'b0;
        dst_ch.t_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(dst_ch.t_valid), 64'd0);
        check("rst_last", 64'(dst_ch.t_last), 64'd0);
        check("rst_keep", 64'(dst_ch.t_keep), 64'd0);
        check("rst_data", dst_ch.t_data, 64'd0);
        check("rst_src_ready", 64'(src_ch.t_ready), 64'd0);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // White (pixel 0) and black (pixel 1), studio range.
        latency_beat("white_black", 64'h00108080_00EB8080, 64'hA5000000_A5FFFFFF);
        check("white_black_keep", 64'(dst_ch.t_keep), 64'hff);
        repeat (4) @(posedge clk);
        #1;

        // Saturated red and its complement, both clamp directions.
        latency_beat("sat", 64'h00913622_00515AF0, 64'hA500FF01_A5FF0000);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure on a 16-beat ramp.
        out_q.delete();
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send({32'h00EB8080, 8'h00, 8'(16 + 8 * i), 16'h8080}, 8'hff, 1'b0);
            end
            begin
                int unsigned c = 0;
                repeat (6) @(posedge clk);
                repeat (5) begin
                    @(posedge clk);
                    #2 dst_ch.t_ready = 1'b0;
                end
                while (out_q.size() < 16 && c < 400) begin
                    @(posedge clk);
                    #2 dst_ch.t_ready = ~dst_ch.t_ready;
                    c++;
                end
                dst_ch.t_ready = 1'b1;
            end
        join
        wait_outputs("bp", 16);
        for (int i = 0; i < 16 && i < out_q.size(); i++)
            check("bp_data", out_q[i].data, {32'hA5FFFFFF, 8'hA5, gray[i], gray[i], gray[i]});

        // Two back-to-back 8-beat packets.
        out_q.delete();
        for (int i = 0; i < 16; i++)
            send(64'h00108080_00EB8080, 8'hff, (i == 7) || (i == 15));
        wait_outputs("frame", 16);
        for (int i = 0; i < 16 && i < out_q.size(); i++)
            check("frame_last", 64'(out_q[i].last), 64'((i == 7) || (i == 15)));

        // Partial keep and fully dead beat carrying t_last.
        out_q.delete();
        send(64'h00EB8080_00EB8080, 8'h0f, 1'b0);
        send(64'h00EB8080_00EB8080, 8'h00, 1'b1);
        wait_outputs("keep", 2);
        if (out_q.size() == 2) begin
            check("keep_half_data", out_q[0].data, 64'h00000000_A5FFFFFF);
            check("keep_half_kl", {55'd0, out_q[0].keep, out_q[0].last}, {55'd0, 8'h0f, 1'b0});
            check("keep_dead_data", out_q[1].data, 64'd0);
            check("keep_dead_kl", {55'd0, out_q[1].keep, out_q[1].last}, {55'd0, 8'h00, 1'b1});
        end

        // Reset with three beats in flight.
        out_q.delete();
        send(64'h00EB8080_00EB8080, 8'hff, 1'b0);
        send(64'h00EB8080_00EB8080, 8'hff, 1'b0);
        send(64'h00EB8080_00EB8080, 8'hff, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midrst_valid", 64'(dst_ch.t_valid), 64'd0);
        check("midrst_src_ready", 64'(src_ch.t_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(out_q.size()), 64'd0);
        latency_beat("post_rst", 64'h00913622_00515AF0, 64'hA500FF01_A5FF0000);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_count", 64'(out_q.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
